two_digit_seg_encoder: RTL and testbench

TWO_DIGIT_SEG_ENCODER -- requirements
Module: two_digit_seg_encoder

---
 rtl/two_digit_seg_encoder_if.sv | 15 +
 rtl/two_digit_seg_encoder.sv | 92 +++++++++
 tb/tb_two_digit_seg_encoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/two_digit_seg_encoder_if.sv
// Value-in / segment-pattern-out bundle for the two-digit 7-segment encoder.
// slave is the encoder side; master is the upstream/display side.
interface two_digit_seg_encoder_if;
    logic        in_valid;
    logic [6:0]  in_value;
    logic        in_ready;
    logic [13:0] both7seg;
    logic        out_update;
    logic        busy;

    modport master (output in_valid, in_value,
                    input  in_ready, both7seg, out_update, busy);
    modport slave  (input  in_valid, in_value,
                    output in_ready, both7seg, out_update, busy);
endinterface

// File: rtl/two_digit_seg_encoder.sv
// Converts a 7-bit binary value to two 7-segment digit patterns by repeated
// subtraction of 10; values of 100 and above display as dash/dash.
module two_digit_seg_encoder #(
    parameter bit BLANK_LEADING = 1'b1,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    two_digit_seg_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

    localparam logic [13:0] SEG_OFF = ACTIVE_LOW ? 14'h3FFF : 14'h0000;
    localparam logic [6:0]  DASH    = 7'h40;

    state_t      state;
    logic [6:0]  rem;
    logic [3:0]  tens;
    logic        ovf;
    logic [13:0] pat;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    endfunction

    // rem is below 10 whenever LOAD is reached, so its low nibble is the digit.
    always_comb begin
        pat = {seg(tens), seg(rem[3:0])};
        if (ovf)
            pat = {DASH, DASH};
        else if (BLANK_LEADING && tens == 4'd0)
            pat[13:7] = 7'h00;
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rem            <= '0;
            tens           <= '0;
            ovf            <= 1'b0;
            bus.out_update <= 1'b0;
            bus.both7seg   <= SEG_OFF;
        end else begin
            bus.out_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_value <= 7'd99) begin
                            rem   <= bus.in_value;
                            tens  <= '0;
                            ovf   <= 1'b0;
                            state <= DIV;
                        end else begin
                            ovf   <= 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DIV: begin
                    if (rem >= 7'd10) begin
                        rem  <= rem - 7'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bus.both7seg   <= ACTIVE_LOW ? ~pat : pat;
                    bus.out_update <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_two_digit_seg_encoder.sv
// Randomized bench for two_digit_seg_encoder: three parameter variants share
// one stimulus stream and are scored against a divide/modulo reference model.
module tb_two_digit_seg_encoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_value;
    int         checks = 0;
    int         errors = 0;

    localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    two_digit_seg_encoder_if bus_d ();  // defaults
    two_digit_seg_encoder_if bus_b ();  // BLANK_LEADING=0
    two_digit_seg_encoder_if bus_a ();  // ACTIVE_LOW=1

    assign bus_d.in_valid = in_valid;
    assign bus_d.in_value = in_value;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_value = in_value;
    assign bus_a.in_valid = in_valid;
    assign bus_a.in_value = in_value;

    two_digit_seg_encoder dut_d (.clk(clk), .rst(rst), .bus(bus_d));
    two_digit_seg_encoder #(.BLANK_LEADING(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    two_digit_seg_encoder #(.ACTIVE_LOW(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] model(input int v, input bit bl, input bit al);
        logic [13:0] r;
        if (v > 99)
            r = {7'h40, 7'h40};
        else
            r = {(bl && v / 10 == 0) ? 7'h00 : CODES[v / 10], CODES[v % 10]};
        return al ? ~r : r;
    endfunction

    function automatic int model_lat(input int v);
        return (v > 99) ? 1 : v / 10 + 2;
    endfunction

    // Called at a negedge with the encoders idle. Optionally leaves in_valid
    // high with the next value while busy; it must be taken only once ready.
    task automatic run_xfer(input int v, input bit hold, input int nxt);
        int lat;
        chk("ready_idle", bus_d.in_ready, 1);
        in_valid = 1'b1;
        in_value = 7'(v);
        @(negedge clk);
        chk("pulse_once", bus_d.out_update, 0);
        chk("ready_busy", bus_d.in_ready, 0);
        chk("busy", bus_d.busy, 1);
        if (hold) in_value = 7'(nxt);
        else      in_valid = 1'b0;
        lat = 0;
        while (!bus_d.out_update && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("lat_%0d", v), lat, model_lat(v));
        chk($sformatf("seg_d_%0d", v), bus_d.both7seg, model(v, 1, 0));
        chk($sformatf("seg_b_%0d", v), bus_b.both7seg, model(v, 0, 0));
        chk($sformatf("seg_a_%0d", v), bus_a.both7seg, model(v, 1, 1));
        chk("upd_b", bus_b.out_update, 1);
        chk("upd_a", bus_a.out_update, 1);
    endtask

    initial begin
        int v, nxt, gap;
        bit hold, saw;
        rst = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        repeat (2) @(negedge clk);
        chk("rst_seg_d", bus_d.both7seg, 14'h0000);
        chk("rst_seg_a", bus_a.both7seg, 14'h3FFF);
        chk("rst_upd", bus_d.out_update, 0);
        chk("rst_busy", bus_d.busy, 0);
        in_valid = 1'b1;  // rst wins over a simultaneous transfer
        in_value = 7'd42;
        @(negedge clk);
        chk("rst_prio", bus_d.in_ready, 1);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed points, including 99 with 5 held during the conversion.
        run_xfer(42, 0, 0);
        run_xfer(99, 1, 5);
        run_xfer(5, 0, 0);
        run_xfer(0, 0, 0);
        run_xfer(7, 0, 0);
        run_xfer(120, 0, 0);
        run_xfer(100, 0, 0);
        run_xfer(127, 0, 0);
        run_xfer(10, 0, 0);

        // Reset during the third DIV cycle of 80 aborts with no pulse.
        in_valid = 1'b1;
        in_value = 7'd80;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_seg", bus_d.both7seg, 14'h0000);
        chk("abort_seg_a", bus_a.both7seg, 14'h3FFF);
        chk("abort_ready", bus_d.in_ready, 1);
        saw = bus_d.out_update;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            saw |= bus_d.out_update;
        end
        chk("abort_noupd", saw, 0);
        run_xfer(13, 0, 0);

        // Random values; held-next transfers chain back-to-back.
        v = $urandom_range(0, 127);
        for (int n = 0; n < 60; n++) begin
            nxt  = $urandom_range(0, 127);
            hold = ($urandom_range(0, 2) == 0);
            run_xfer(v, hold, nxt);
            if (!hold) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("hold_seg", bus_d.both7seg, model(v, 1, 0));
                    chk("idle_upd", bus_d.out_update, 0);
                end
            end
            v = nxt;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("final_upd", bus_d.out_update, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
